// File: rtl/truth_table_scanner.sv
// Exhaustive truth-table scanner: walks minterms 0..15 on {x,y,w,z}, captures
// three function outputs into masks, then compares them against expected masks.
module truth_table_scanner #(
    parameter logic [15:0] EXP_C = 16'h5266,
    parameter logic [15:0] EXP_D = 16'h16C5,
    parameter logic [15:0] EXP_E = 16'h20AE
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        start,
    output logic        x,
    output logic        y,
    output logic        w,
    output logic        z,
    input  logic        sC,
    input  logic        sD,
    input  logic        sE,
    output logic        busy,
    output logic        done,
    output logic [15:0] mask_c,
    output logic [15:0] mask_d,
    output logic [15:0] mask_e,
    output logic        err_c,
    output logic        err_d,
    output logic        err_e,
    output logic        pass,
    output logic [3:0]  first_fail
);

    typedef enum logic [2:0] {
        S_IDLE,
        S_DRIVE,
        S_SAMPLE,
        S_CHECK,
        S_DONE
    } state_t;

    state_t      state, state_nxt;
    logic [3:0]  idx, idx_nxt;
    logic        accept;
    logic        capture;
    logic        evaluate;
    logic [15:0] diff;
    logic [3:0]  drive;

    // Index of the lowest set bit; 0 when no bit is set.
    function automatic logic [3:0] lowest_set(input logic [15:0] v);
        logic [3:0] r;
        r = 4'd0;
        for (int i = 15; i >= 0; i--) begin
            if (v[i]) r = 4'(i);
        end
        return r;
    endfunction

    // NOTE: sequential state uses non-blocking assignments so every register
    // samples the pre-edge values of its peers, independent of block order.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state <= S_IDLE;
            idx   <= 4'd0;
        end else begin
            state <= state_nxt;
            idx   <= idx_nxt;
        end
    end

    // NOTE: every signal gets a default before the case so no path leaves a
    // value unassigned, which would otherwise infer a latch.
    always_comb begin
        state_nxt = state;
        idx_nxt   = idx;
        accept    = 1'b0;
        capture   = 1'b0;
        evaluate  = 1'b0;
        case (state)
            S_IDLE: begin
                if (start) begin
                    accept    = 1'b1;
                    idx_nxt   = 4'd0;
                    state_nxt = S_DRIVE;
                end
            end
            S_DRIVE: begin
                state_nxt = S_SAMPLE;
            end
            S_SAMPLE: begin
                capture = 1'b1;
                if (idx == 4'd15) begin
                    state_nxt = S_CHECK;
                end else begin
                    idx_nxt   = idx + 4'd1;
                    state_nxt = S_DRIVE;
                end
            end
            S_CHECK: begin
                evaluate  = 1'b1;
                state_nxt = S_DONE;
            end
            S_DONE: begin
                state_nxt = S_IDLE;
            end
            default: begin
                state_nxt = S_IDLE;
            end
        endcase
    end

    // Outputs decode directly from registered state, so reset clears them at once.
    assign busy  = (state == S_DRIVE) || (state == S_SAMPLE) || (state == S_CHECK);
    assign done  = (state == S_DONE);
    assign drive = ((state == S_DRIVE) || (state == S_SAMPLE)) ? idx : 4'd0;
    assign {x, y, w, z} = drive;

    // NOTE: the capture masks are plain flops, not a memory, so they take the
    // async reset like any other register.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            mask_c <= 16'd0;
            mask_d <= 16'd0;
            mask_e <= 16'd0;
        end else if (accept) begin
            mask_c <= 16'd0;
            mask_d <= 16'd0;
            mask_e <= 16'd0;
        end else if (capture) begin
            mask_c[idx] <= sC;
            mask_d[idx] <= sD;
            mask_e[idx] <= sE;
        end
    end

    assign diff = (mask_c ^ EXP_C) | (mask_d ^ EXP_D) | (mask_e ^ EXP_E);

    // Verdict registers hold from CHECK until the next accepted start.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            err_c      <= 1'b0;
            err_d      <= 1'b0;
            err_e      <= 1'b0;
            pass       <= 1'b0;
            first_fail <= 4'd0;
        end else if (accept) begin
            err_c      <= 1'b0;
            err_d      <= 1'b0;
            err_e      <= 1'b0;
            pass       <= 1'b0;
            first_fail <= 4'd0;
        end else if (evaluate) begin
            err_c      <= (mask_c != EXP_C);
            err_d      <= (mask_d != EXP_D);
            err_e      <= (mask_e != EXP_E);
            pass       <= (diff == 16'd0);
            first_fail <= lowest_set(diff);
        end
    end

endmodule

// File: tb/tb_truth_table_scanner.sv
// Scoreboard bench for truth_table_scanner: a behavioural function block and a
// timeline model predict every cycle; a separate monitor pops results on done.
module tb_truth_table_scanner;

    localparam logic [15:0] EXP_C = 16'h5266;
    localparam logic [15:0] EXP_D = 16'h16C5;
    localparam logic [15:0] EXP_E = 16'h20AE;

    typedef struct packed {
        logic [15:0] mask_c;
        logic [15:0] mask_d;
        logic [15:0] mask_e;
        logic        err_c;
        logic        err_d;
        logic        err_e;
        logic        pass;
        logic [3:0]  first_fail;
    } exp_t;

    logic        clk;
    logic        rst;
    logic        start;
    logic        x, y, w, z;
    logic        sC, sD, sE;
    logic        busy, done;
    logic [15:0] mask_c, mask_d, mask_e;
    logic        err_c, err_d, err_e, pass;
    logic [3:0]  first_fail;

    logic [15:0] fn_c, fn_d, fn_e;
    logic [3:0]  m_idx;

    int   checks = 0;
    int   errors = 0;
    int   cycle_no = 0;
    int   cyc = -1;
    bit   res_valid = 1'b0;
    exp_t cur = '0;
    exp_t sb_q[$];

    truth_table_scanner #(
        .EXP_C(EXP_C),
        .EXP_D(EXP_D),
        .EXP_E(EXP_E)
    ) dut (
        .clk(clk),
        .rst(rst),
        .start(start),
        .x(x),
        .y(y),
        .w(w),
        .z(z),
        .sC(sC),
        .sD(sD),
        .sE(sE),
        .busy(busy),
        .done(done),
        .mask_c(mask_c),
        .mask_d(mask_d),
        .mask_e(mask_e),
        .err_c(err_c),
        .err_d(err_d),
        .err_e(err_e),
        .pass(pass),
        .first_fail(first_fail)
    );

    // Function block under test: each output is its truth table looked up by minterm.
    assign m_idx = {x, y, w, z};
    assign sC = fn_c[m_idx];
    assign sD = fn_d[m_idx];
    assign sE = fn_e[m_idx];

    initial clk = 1'b0;
    always #5 clk = ~clk;

    always @(posedge clk) cycle_no <= cycle_no + 1;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] req);
        checks++;
        if (act !== req) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h (cycle %0d)", name, act, req, cycle_no);
        end
    endtask

    function automatic exp_t calc_exp(input logic [15:0] fc, input logic [15:0] fd, input logic [15:0] fe);
        exp_t        e;
        logic [15:0] dc, dd, de;
        bit          found;
        dc = fc ^ EXP_C;
        dd = fd ^ EXP_D;
        de = fe ^ EXP_E;
        e.mask_c = fc;
        e.mask_d = fd;
        e.mask_e = fe;
        e.err_c  = (dc != 16'd0);
        e.err_d  = (dd != 16'd0);
        e.err_e  = (de != 16'd0);
        e.pass   = !(e.err_c || e.err_d || e.err_e);
        e.first_fail = 4'd0;
        found = 1'b0;
        for (int m = 0; m < 16; m++) begin
            if (!found && (dc[m] || dd[m] || de[m])) begin
                e.first_fail = 4'(m);
                found = 1'b1;
            end
        end
        return e;
    endfunction

    // Timeline model: cyc counts edges since an accepted start, -1 when idle.
    always @(posedge clk or posedge rst) begin
        if (rst) begin
            cyc       <= -1;
            res_valid <= 1'b0;
            sb_q.delete();
        end else if (cyc < 0) begin
            if (start) begin
                cyc       <= 0;
                res_valid <= 1'b0;
                cur       <= calc_exp(fn_c, fn_d, fn_e);
                sb_q.push_back(calc_exp(fn_c, fn_d, fn_e));
            end
        end else if (cyc == 33) begin
            cyc <= -1;
        end else begin
            if (cyc == 32) res_valid <= 1'b1;
            cyc <= cyc + 1;
        end
    end

    // Per-cycle checker: handshake, minterm drive and partial/final result registers.
    always @(negedge clk) begin : timeline_mon
        exp_t        shown;
        logic [15:0] keep;
        int          n;
        if (!rst) begin
            shown = '0;
            if (cyc >= 0 && cyc <= 32) begin
                n = cyc / 2;
                keep = 16'((32'd1 << n) - 32'd1);
                shown.mask_c = cur.mask_c & keep;
                shown.mask_d = cur.mask_d & keep;
                shown.mask_e = cur.mask_e & keep;
            end else if (cyc == 33 || res_valid) begin
                shown = cur;
            end
            check("busy", 32'(busy), 32'(cyc >= 0 && cyc <= 32));
            check("done", 32'(done), 32'(cyc == 33));
            check("xywz", 32'({x, y, w, z}), (cyc >= 0 && cyc <= 31) ? 32'(cyc / 2) : 32'd0);
            check("mask_c", 32'(mask_c), 32'(shown.mask_c));
            check("mask_d", 32'(mask_d), 32'(shown.mask_d));
            check("mask_e", 32'(mask_e), 32'(shown.mask_e));
            check("errs", 32'({err_c, err_d, err_e}), 32'({shown.err_c, shown.err_d, shown.err_e}));
            check("pass", 32'(pass), 32'(shown.pass));
            check("first_fail", 32'(first_fail), 32'(shown.first_fail));
        end
    end

    // Scoreboard monitor: each done pulse consumes one expected result.
    always @(negedge clk) begin : sb_mon
        exp_t e;
        if (!rst && done) begin
            if (sb_q.size() == 0) begin
                check("sb_unexpected_done", 32'd1, 32'd0);
            end else begin
                e = sb_q.pop_front();
                check("sb_mask_c", 32'(mask_c), 32'(e.mask_c));
                check("sb_mask_d", 32'(mask_d), 32'(e.mask_d));
                check("sb_mask_e", 32'(mask_e), 32'(e.mask_e));
                check("sb_errs", 32'({err_c, err_d, err_e}), 32'({e.err_c, e.err_d, e.err_e}));
                check("sb_pass", 32'(pass), 32'(e.pass));
                check("sb_first_fail", 32'(first_fail), 32'(e.first_fail));
            end
        end
    end

    task automatic check_zero(input string tag);
        check({tag, "_busy"}, 32'(busy), 32'd0);
        check({tag, "_done"}, 32'(done), 32'd0);
        check({tag, "_xywz"}, 32'({x, y, w, z}), 32'd0);
        check({tag, "_masks"}, 32'({mask_c, mask_d}), 32'd0);
        check({tag, "_mask_e"}, 32'(mask_e), 32'd0);
        check({tag, "_flags"}, 32'({err_c, err_d, err_e, pass, first_fail}), 32'd0);
    endtask

    task automatic wait_done(input int budget, output int when);
        int n;
        n = 0;
        when = -1;
        do begin
            @(negedge clk);
            n++;
        end while (!done && n < budget);
        if (done) when = cycle_no;
        else check("wait_done_timeout", 32'd0, 32'd1);
    endtask

    task automatic wait_cyc(input int target);
        int n;
        n = 0;
        while (cyc != target && n < 100) begin
            @(negedge clk);
            n++;
        end
        if (cyc != target) check("wait_cyc_timeout", 32'(cyc), 32'(target));
    endtask

    task automatic pulse_start();
        @(negedge clk);
        start = 1'b1;
        @(negedge clk);
        start = 1'b0;
    endtask

    task automatic set_fn(input logic [15:0] c, input logic [15:0] d, input logic [15:0] e);
        fn_c = c;
        fn_d = d;
        fn_e = e;
    endtask

    initial begin : stim
        int t1, t2, mode, sel, bitn;
        rst   = 1'b1;
        start = 1'b0;
        set_fn(EXP_C, EXP_D, EXP_E);
        repeat (3) @(negedge clk);
        check_zero("reset");
        #2 rst = 1'b0;

        // Golden block, then the two stuck-output faults.
        pulse_start();
        wait_done(60, t1);
        set_fn(16'h0000, EXP_D, EXP_E);
        pulse_start();
        wait_done(60, t1);
        set_fn(EXP_C, EXP_D, 16'hFFFF);
        pulse_start();
        wait_done(60, t1);

        // Reset while sampling minterm 7, then restart on the first edge after release.
        set_fn(EXP_C, EXP_D, EXP_E);
        pulse_start();
        wait_cyc(15);
        check("pre_rst_xywz", 32'({x, y, w, z}), 32'd7);
        #2 rst = 1'b1;
        #1 check_zero("rst_mid");
        @(negedge clk);
        #2 rst = 1'b0;
        start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        wait_done(60, t1);

        // Start re-pulsed at edge 10 is ignored.
        pulse_start();
        wait_cyc(9);
        start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        wait_done(60, t1);
        repeat (40) @(negedge clk);

        // Start held high: back-to-back scans 35 edges apart.
        @(negedge clk);
        start = 1'b1;
        wait_done(60, t1);
        wait_done(60, t2);
        start = 1'b0;
        check("held_done_gap", 32'(t2 - t1), 32'd35);
        repeat (40) @(negedge clk);

        // Randomised function tables, gaps and ignored mid-scan starts.
        for (int i = 0; i < 14; i++) begin
            mode = $urandom_range(0, 3);
            case (mode)
                0: set_fn(EXP_C, EXP_D, EXP_E);
                1: set_fn(16'($urandom), 16'($urandom), 16'($urandom));
                2: begin
                    set_fn(EXP_C, EXP_D, EXP_E);
                    sel  = $urandom_range(0, 2);
                    bitn = $urandom_range(0, 15);
                    if (sel == 0) fn_c = fn_c ^ (16'd1 << bitn);
                    else if (sel == 1) fn_d = fn_d ^ (16'd1 << bitn);
                    else fn_e = fn_e ^ (16'd1 << bitn);
                end
                default: set_fn($urandom_range(0, 1) ? EXP_C : 16'h0000,
                                $urandom_range(0, 1) ? EXP_D : 16'hFFFF,
                                $urandom_range(0, 1) ? EXP_E : 16'h0000);
            endcase
            repeat ($urandom_range(0, 3)) @(negedge clk);
            pulse_start();
            if ($urandom_range(0, 1) == 1) begin
                repeat ($urandom_range(1, 30)) @(negedge clk);
                start = 1'b1;
                @(negedge clk);
                start = 1'b0;
            end
            wait_done(60, t1);
        end

        repeat (5) @(negedge clk);
        check("sb_queue_empty", 32'(sb_q.size()), 32'd0);
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

    initial begin : watchdog
        #200000;
        $display("FAIL watchdog: simulation did not finish, cycle %0d", cycle_no);
        $fatal(1, "watchdog expired");
    end

endmodule
